// File: rtl/riscv_pkg.sv
// Shared register map for the memory-mapped machine timer: word offsets,
// ctrl/status bit positions and the mtimecmp reset value.
package riscv_pkg;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_STATUS      = 3'd5,
    REG_RSVD6       = 3'd6,
    REG_RSVD7       = 3'd7
  } reg_off_e;

  localparam int CTRL_EN_BIT      = 0;
  localparam int STATUS_PEND_BIT  = 0;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Place a single flag at a given bit position of a 32-bit register word.
  function automatic logic [31:0] flag_word(input logic flag, input int pos);
    logic [31:0] w;
    w = '0;
    w[pos] = flag;
    return w;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..Prescale-1 while enabled and emits a one-cycle tick
// on the terminal count.
module tick_gen #(
  parameter int Prescale = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = en && (cnt == 16'(Prescale - 1));

  // Count stage: a ctrl write restarts the count even while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? 16'd0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt, decoded from a
// 32-byte register window on the core data port.
module mmio_timer
  import riscv_pkg::*;
#(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] BaseAddr = 32'h0000_2000,
  parameter int               Prescale = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] ALU_Result,
  input  logic             Mem_Write,
  input  logic [Width-1:0] Write_Data,
  output logic [Width-1:0] rd_data,
  output logic             sel,
  output logic             timer_irq
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        en;
  logic        tick;
  logic        wr;
  logic        pending;
  logic [31:0] wdata;
  logic [31:0] rd_word;
  reg_off_e    off;
  logic        unused_bits;

  assign sel         = (ALU_Result[Width-1:5] == BaseAddr[Width-1:5]);
  assign wr          = sel && Mem_Write;
  assign off         = reg_off_e'(ALU_Result[4:2]);
  assign wdata       = Write_Data[31:0];
  assign unused_bits = ^{ALU_Result[1:0], Write_Data};

  // Unsigned 64-bit compare; gated by en so clearing en drops the request.
  assign pending = en && (mtime >= mtimecmp);

  tick_gen #(
    .Prescale(Prescale)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (wr && (off == REG_CTRL)),
    .tick (tick)
  );

  // Register stage: a software write to either mtime half wins over a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      en        <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= pending;
      if (wr && (off == REG_MTIME_LO)) begin
        mtime <= {mtime[63:32], wdata};
      end else if (wr && (off == REG_MTIME_HI)) begin
        mtime <= {wdata, mtime[31:0]};
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (wr && (off == REG_MTIMECMP_LO)) mtimecmp[31:0]  <= wdata;
      if (wr && (off == REG_MTIMECMP_HI)) mtimecmp[63:32] <= wdata;
      if (wr && (off == REG_CTRL))        en              <= wdata[CTRL_EN_BIT];
    end
  end

  always_comb begin
    rd_word = '0;
    if (sel) begin
      case (off)
        REG_MTIME_LO:    rd_word = mtime[31:0];
        REG_MTIME_HI:    rd_word = mtime[63:32];
        REG_MTIMECMP_LO: rd_word = mtimecmp[31:0];
        REG_MTIMECMP_HI: rd_word = mtimecmp[63:32];
        REG_CTRL:        rd_word = flag_word(en, CTRL_EN_BIT);
        REG_STATUS:      rd_word = flag_word(pending, STATUS_PEND_BIT);
        default:         rd_word = '0;
      endcase
    end
  end

  assign rd_data = Width'(rd_word);

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: two instances (Prescale 1 and 4) share one bus and are
// compared against a cycle-level reference model of the timer's rules.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ALU_Result = IDLE;
  logic        Mem_Write = 1'b0;
  logic [31:0] Write_Data = '0;

  logic [31:0] rd_a, rd_b;
  logic        sel_a, sel_b, irq_a, irq_b;

  int checks = 0;
  int failures = 0;

  // Model state: index 0 -> Prescale 1, index 1 -> Prescale 4
  int          pre [2] = '{1, 4};
  logic [63:0] m_time [2];
  logic [63:0] m_cmp [2];
  logic        m_en [2];
  int          m_ecyc [2];
  logic        m_irq [2];

  always #10 clk = ~clk;

  mmio_timer #(.Width(32), .BaseAddr(BASE), .Prescale(1)) dut_a (
    .clk(clk), .reset(reset), .ALU_Result(ALU_Result), .Mem_Write(Mem_Write),
    .Write_Data(Write_Data), .rd_data(rd_a), .sel(sel_a), .timer_irq(irq_a));

  mmio_timer #(.Width(32), .BaseAddr(BASE), .Prescale(4)) dut_b (
    .clk(clk), .reset(reset), .ALU_Result(ALU_Result), .Mem_Write(Mem_Write),
    .Write_Data(Write_Data), .rd_data(rd_b), .sel(sel_b), .timer_irq(irq_b));

  function automatic logic [31:0] A(input int o);
    return BASE + 32'(o * 4);
  endfunction

  function automatic logic [31:0] got_rd(input int i);
    return (i == 0) ? rd_a : rd_b;
  endfunction

  function automatic logic got_irq(input int i);
    return (i == 0) ? irq_a : irq_b;
  endfunction

  function automatic logic got_sel(input int i);
    return (i == 0) ? sel_a : sel_b;
  endfunction

  function automatic logic m_inwin(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic m_pend(input int i);
    return m_en[i] && (m_time[i] >= m_cmp[i]);
  endfunction

  function automatic logic [31:0] m_rd(input int i, input logic [31:0] a);
    if (!m_inwin(a)) return 32'd0;
    case (a[4:2])
      3'd0: return m_time[i][31:0];
      3'd1: return m_time[i][63:32];
      3'd2: return m_cmp[i][31:0];
      3'd3: return m_cmp[i][63:32];
      3'd4: return {31'd0, m_en[i]};
      3'd5: return {31'd0, m_pend(i)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_time[i] = 64'd0;
      m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en[i]   = 1'b0;
      m_ecyc[i] = 0;
      m_irq[i]  = 1'b0;
    end
  endtask

  // One clock with the given bus cycle; the model advances alongside.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic w, tk, pd;
    int o;
    ALU_Result = a;
    Mem_Write  = we;
    Write_Data = d;
    w = we && m_inwin(a);
    o = int'(a[4:2]);
    for (int i = 0; i < 2; i++) begin
      tk = m_en[i] && ((m_ecyc[i] % pre[i]) == pre[i] - 1);
      pd = m_pend(i);
      m_irq[i] = pd;
      if (w && o == 0)      m_time[i][31:0]  = d;
      else if (w && o == 1) m_time[i][63:32] = d;
      else if (tk)          m_time[i] = m_time[i] + 64'd1;
      if (w && o == 2) m_cmp[i][31:0]  = d;
      if (w && o == 3) m_cmp[i][63:32] = d;
      if (w && o == 4) begin
        m_en[i]   = d[0];
        m_ecyc[i] = 0;
      end else if (m_en[i]) begin
        m_ecyc[i] = (m_ecyc[i] + 1) % pre[i];
      end
    end
    @(posedge clk);
    #1;
    Mem_Write  = 1'b0;
    ALU_Result = IDLE;
  endtask

  task automatic peek(input logic [31:0] a);
    ALU_Result = a;
    Mem_Write  = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    Mem_Write = 1'b0;
    ALU_Result = IDLE;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int o = 0; o < 6; o++) begin
      peek(A(o));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_rd(i) !== m_rd(i, A(o))) begin
          failures++;
          $display("FAIL reset_rd[%0d] off=%0d: got %h expected %h", i, o, got_rd(i), m_rd(i, A(o)));
        end
      end
    end
    peek(A(2));
    checks++;
    if (rd_a !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL reset_cmp_lo: got %h expected ffffffff", rd_a);
    end
    checks++;
    if (sel_a !== 1'b1 || irq_a !== 1'b0 || irq_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_sel_irq: got sel=%b irq=%b/%b expected sel=1 irq=0/0", sel_a, irq_a, irq_b);
    end
    reset = 1'b0;
    ALU_Result = IDLE;
  endtask

  task automatic test_prescale();
    apply_reset();
    cycle(1'b1, A(4), 32'd1);
    repeat (4) cycle(1'b0, IDLE, 32'd0);
    peek(A(0));
    checks++;
    if (rd_b !== 32'd1) begin
      failures++;
      $display("FAIL presc4_after4: got %0d expected 1", rd_b);
    end
    checks++;
    if (rd_a !== m_rd(0, A(0))) begin
      failures++;
      $display("FAIL presc1_after4: got %0d expected %0d", rd_a, m_rd(0, A(0)));
    end
    repeat (16) cycle(1'b0, IDLE, 32'd0);
    peek(A(0));
    checks++;
    if (rd_b !== 32'd5) begin
      failures++;
      $display("FAIL presc4_after20: got %0d expected 5", rd_b);
    end
    checks++;
    if (rd_a !== 32'd20) begin
      failures++;
      $display("FAIL presc1_after20: got %0d expected 20", rd_a);
    end
  endtask

  task automatic test_carry();
    apply_reset();
    cycle(1'b1, A(0), 32'hFFFF_FFFF);
    cycle(1'b1, A(1), 32'h0);
    cycle(1'b1, A(4), 32'd1);
    cycle(1'b0, IDLE, 32'd0);
    peek(A(1));
    checks++;
    if (rd_a !== 32'd1) begin
      failures++;
      $display("FAIL carry_hi: got %h expected 00000001", rd_a);
    end
    peek(A(0));
    checks++;
    if (rd_a !== 32'd0) begin
      failures++;
      $display("FAIL carry_lo: got %h expected 00000000", rd_a);
    end
    checks++;
    if (rd_b !== m_rd(1, A(0))) begin
      failures++;
      $display("FAIL carry_lo_p4: got %h expected %h", rd_b, m_rd(1, A(0)));
    end
  endtask

  task automatic test_cmp_irq();
    logic saw_pend, expect_irq;
    apply_reset();
    cycle(1'b1, A(2), 32'd10);
    cycle(1'b1, A(3), 32'd0);
    cycle(1'b1, A(4), 32'd1);
    saw_pend = 1'b0;
    expect_irq = 1'b0;
    for (int k = 0; k < 14; k++) begin
      peek(A(5));
      checks++;
      if (rd_a !== m_rd(0, A(5)) || irq_a !== m_irq[0]) begin
        failures++;
        $display("FAIL cmp_status t=%0d: got pend=%b irq=%b expected pend=%b irq=%b",
                 k, rd_a[0], irq_a, m_pend(0), m_irq[0]);
      end
      if (expect_irq) begin
        checks++;
        if (irq_a !== 1'b1) begin
          failures++;
          $display("FAIL cmp_irq_latency: got %b expected 1", irq_a);
        end
        expect_irq = 1'b0;
      end
      if (m_time[0] == 64'd10) begin
        saw_pend = 1'b1;
        expect_irq = 1'b1;
        checks++;
        if (rd_a !== 32'd1) begin
          failures++;
          $display("FAIL cmp_pend_at10: got %h expected 00000001", rd_a);
        end
      end
      cycle(1'b0, IDLE, 32'd0);
    end
    checks++;
    if (saw_pend !== 1'b1) begin
      failures++;
      $display("FAIL cmp_reached10: got %b expected 1", saw_pend);
    end
    // Clearing en must drop the interrupt one cycle later.
    cycle(1'b1, A(4), 32'd0);
    checks++;
    if (irq_a !== 1'b1) begin
      failures++;
      $display("FAIL irq_before_clear: got %b expected 1", irq_a);
    end
    cycle(1'b0, IDLE, 32'd0);
    checks++;
    if (irq_a !== 1'b0) begin
      failures++;
      $display("FAIL irq_after_clear: got %b expected 0", irq_a);
    end
  endtask

  task automatic test_tick_write();
    apply_reset();
    cycle(1'b1, A(4), 32'd1);
    repeat (3) cycle(1'b0, IDLE, 32'd0);
    cycle(1'b1, A(0), 32'h55);
    peek(A(0));
    checks++;
    if (rd_a !== 32'h55) begin
      failures++;
      $display("FAIL tickwr_lo: got %h expected 00000055", rd_a);
    end
    checks++;
    if (rd_b !== m_rd(1, A(0))) begin
      failures++;
      $display("FAIL tickwr_lo_p4: got %h expected %h", rd_b, m_rd(1, A(0)));
    end
    cycle(1'b1, A(1), 32'h12);
    peek(A(0));
    checks++;
    if (rd_a !== 32'h55) begin
      failures++;
      $display("FAIL tickwr_hi_holds_lo: got %h expected 00000055", rd_a);
    end
    peek(A(1));
    checks++;
    if (rd_a !== 32'h12) begin
      failures++;
      $display("FAIL tickwr_hi: got %h expected 00000012", rd_a);
    end
    cycle(1'b0, IDLE, 32'd0);
    peek(A(0));
    checks++;
    if (rd_a !== 32'h56) begin
      failures++;
      $display("FAIL tickwr_resume: got %h expected 00000056", rd_a);
    end
  endtask

  task automatic test_reset_irq();
    apply_reset();
    cycle(1'b1, A(0), 32'd99);
    cycle(1'b1, A(2), 32'd50);
    cycle(1'b1, A(3), 32'd0);
    cycle(1'b1, A(4), 32'd1);
    cycle(1'b0, IDLE, 32'd0);
    peek(A(0));
    checks++;
    if (rd_a !== 32'd100 || irq_a !== 1'b1) begin
      failures++;
      $display("FAIL rstirq_setup: got mtime=%0d irq=%b expected 100 1", rd_a, irq_a);
    end
    reset = 1'b1;
    #1;
    peek(A(0));
    checks++;
    if (irq_a !== 1'b0 || rd_a !== 32'd0) begin
      failures++;
      $display("FAIL rstirq_async: got irq=%b mtime=%0d expected 0 0", irq_a, rd_a);
    end
    peek(A(2));
    checks++;
    if (rd_a !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL rstirq_cmp: got %h expected ffffffff", rd_a);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_out_of_window();
    logic [31:0] d;
    apply_reset();
    cycle(1'b1, A(0), 32'd3);
    cycle(1'b1, A(2), 32'd7);
    d = $urandom;
    ALU_Result = BASE + 32'h40;
    Mem_Write  = 1'b1;
    Write_Data = d;
    #1;
    checks++;
    if (sel_a !== 1'b0 || rd_a !== 32'd0) begin
      failures++;
      $display("FAIL oow_decode: got sel=%b rd=%h expected sel=0 rd=0", sel_a, rd_a);
    end
    cycle(1'b1, BASE + 32'h40, d);
    cycle(1'b1, A(6), d);
    cycle(1'b1, A(7), d);
    for (int o = 0; o < 8; o++) begin
      peek(A(o));
      checks++;
      if (rd_a !== m_rd(0, A(o)) || rd_b !== m_rd(1, A(o))) begin
        failures++;
        $display("FAIL oow_regs off=%0d: got %h/%h expected %h/%h",
                 o, rd_a, rd_b, m_rd(0, A(o)), m_rd(1, A(o)));
      end
      if (o == 7) cycle(1'b0, IDLE, 32'd0);
    end
    peek(A(0));
    checks++;
    if (rd_a !== 32'd3) begin
      failures++;
      $display("FAIL oow_mtime: got %h expected 00000003", rd_a);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic we;
    int o;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      o = $urandom_range(0, 7);
      a = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : A(o);
      if ($urandom_range(0, 15) == 0) a = A(o) ^ 32'h0000_0040;
      peek(a);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_rd(i) !== m_rd(i, a) || got_sel(i) !== m_inwin(a) || got_irq(i) !== m_irq[i]) begin
          failures++;
          $display("FAIL rand[%0d] k=%0d addr=%h: got rd=%h sel=%b irq=%b expected rd=%h sel=%b irq=%b",
                   i, k, a, got_rd(i), got_sel(i), got_irq(i), m_rd(i, a), m_inwin(a), m_irq[i]);
        end
      end
      we = ($urandom_range(0, 2) == 0);
      case (a[4:2])
        3'd0, 3'd2: d = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                     : 32'($urandom_range(0, 60));
        3'd1, 3'd3: d = ($urandom_range(0, 5) == 0) ? $urandom : 32'd0;
        3'd4:       d = {$urandom_range(0, 1) == 0 ? 31'd0 : 31'h5A5A, $urandom_range(0, 3) != 0};
        default:    d = $urandom;
      endcase
      cycle(we, a, d);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_prescale();
    test_carry();
    test_cmp_irq();
    test_tick_write();
    test_reset_irq();
    test_out_of_window();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
